// File: rtl/rc_issue_ctrl_pkg.sv
// Shared definitions for the RC command-issue controller: channel state
// encodings, default watchdog limit and a constant clog2 helper.
package rc_issue_ctrl_pkg;

  typedef enum logic {
    RC_IDLE = 1'b0,
    RC_BUSY = 1'b1
  } rc_state_e;

  localparam logic RC_0 = 1'b0;
  localparam logic RC_1 = 1'b1;

  localparam int unsigned RC_TIMEOUT_DEFAULT = 255;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rc_chan_fsm.sv
// One RC channel: IDLE/BUSY state plus a saturating watchdog counter.
module rc_chan_fsm
  import rc_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = RC_TIMEOUT_DEFAULT,
  parameter int unsigned TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic done,
  output logic busy,
  output logic busy_nxt,
  output logic expire,
  output logic spurious
);

  rc_state_e       state_q;
  logic [TO_W-1:0] cnt_q;
  logic            at_limit;

  always_comb begin
    at_limit = 1'b0;
    if (TIMEOUT_CYC != 0) at_limit = (cnt_q == TO_W'(TIMEOUT_CYC - 1));
  end

  assign busy     = (state_q == RC_BUSY);
  // A done pulse on the expiry cycle takes precedence over the timeout.
  assign expire   = busy & at_limit & ~done;
  assign spurious = ~busy & done;
  assign busy_nxt = busy ? ~(done | at_limit) : start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RC_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        RC_IDLE: begin
          if (start) begin
            state_q <= RC_BUSY;
            cnt_q   <= '0;
          end
        end
        RC_BUSY: begin
          if (done || at_limit) state_q <= RC_IDLE;
          else if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= RC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rc_issue_ctrl.sv
// Multi-channel RC command-issue controller: accept/stall logic, per-channel
// FSMs, sticky error flags and a registered busy-channel count.
module rc_issue_ctrl
  import rc_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RC      = 4,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned BLOCKING    = 1,
  parameter int unsigned TIMEOUT_CYC = RC_TIMEOUT_DEFAULT,
  parameter int unsigned TO_W        = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           dec_rc_req,
  input  logic [CH_W-1:0]                dec_rc_ch,
  input  logic                           dec_stall,
  input  logic                           dec_kill,
  input  logic                           if_kill,
  input  logic                           exe_dmem_val,
  input  logic                           dmem_resp_valid,
  input  logic [NUM_RC-1:0]              rc_done,
  input  logic                           err_clr,
  output logic [NUM_RC-1:0]              rc_cmd,
  output logic [clog2(NUM_RC+1)-1:0]     rc_active_cnt,
  output logic                           full_stall,
  output logic                           err_timeout,
  output logic [CH_W-1:0]                err_timeout_ch,
  output logic                           err_illegal_ch,
  output logic                           err_spurious
);

  localparam int unsigned CNT_W = clog2(NUM_RC + 1);
  localparam int unsigned PAD_W = ((1 << CH_W) > NUM_RC) ? (1 << CH_W) : NUM_RC;

  logic [PAD_W-1:0]  cmd_pad;
  logic              legal_ch, killed, dmem_stall, ch_busy, ch_block;
  logic              accept, rc_stall, illegal_evt;
  logic [NUM_RC-1:0] busy_nxt, expire, spurious;
  logic [CNT_W-1:0]  cnt_d;
  logic [CH_W-1:0]   first_to;

  // Zero-padded so an out-of-range channel id reads as idle.
  assign cmd_pad    = PAD_W'(rc_cmd);
  assign ch_busy    = cmd_pad[dec_rc_ch];
  assign legal_ch   = (32'(dec_rc_ch) < NUM_RC);
  assign killed     = dec_kill | if_kill;
  assign dmem_stall = exe_dmem_val & ~dmem_resp_valid;
  assign ch_block   = (BLOCKING != 0) ? |rc_cmd : ch_busy;
  assign accept     = dec_rc_req & legal_ch & ~dec_stall & ~killed & ~dmem_stall & ~ch_block;
  assign rc_stall   = (BLOCKING != 0) ? |rc_cmd : (dec_rc_req & legal_ch & ch_busy & ~killed);
  assign full_stall = dmem_stall | rc_stall;
  assign illegal_evt = dec_rc_req & ~legal_ch & ~killed & ~dec_stall & ~dmem_stall;

  for (genvar i = 0; i < NUM_RC; i++) begin : g_chan
    rc_chan_fsm #(
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .TO_W       (TO_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept && (32'(dec_rc_ch) == i)),
      .done    (rc_done[i]),
      .busy    (rc_cmd[i]),
      .busy_nxt(busy_nxt[i]),
      .expire  (expire[i]),
      .spurious(spurious[i])
    );
  end

  always_comb begin
    cnt_d    = '0;
    first_to = '0;
    for (int i = 0; i < NUM_RC; i++) cnt_d = cnt_d + CNT_W'(busy_nxt[i]);
    for (int i = NUM_RC - 1; i >= 0; i--) begin
      if (expire[i]) first_to = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc_active_cnt  <= '0;
      err_timeout    <= 1'b0;
      err_timeout_ch <= '0;
      err_illegal_ch <= 1'b0;
      err_spurious   <= 1'b0;
    end else begin
      rc_active_cnt  <= cnt_d;
      err_timeout    <= (err_timeout & ~err_clr) | (|expire);
      err_illegal_ch <= (err_illegal_ch & ~err_clr) | illegal_evt;
      err_spurious   <= (err_spurious & ~err_clr) | (|spurious);
      if ((|expire) && (!err_timeout || err_clr)) err_timeout_ch <= first_to;
      else if (err_clr) err_timeout_ch <= '0;
    end
  end

endmodule

// File: tb/tb_rc_issue_ctrl.sv
// Scoreboard bench for rc_issue_ctrl across four parameter sets sharing one
// stimulus stream; expectations are keyed by cycle and checked by a monitor.
module tb_rc_issue_ctrl;

  localparam int SC = 0, SN = 1, SFS = 2, STO = 3, STC = 4, SIL = 5, SSP = 6;

  typedef struct {
    int cyc;
    int sel;
    int sig;
    int val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_rc_req, dec_stall, dec_kill, if_kill, exe_dmem_val, dmem_resp_valid, err_clr;
  logic [1:0] dec_rc_ch;
  logic [3:0] rc_done;

  logic [3:0] cmd [3];
  logic [2:0] cnt [3];
  logic [2:0] cmd3;
  logic [1:0] cnt3;
  logic       fs [4], eto [4], eil [4], esp [4];
  logic [1:0] etc [4];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sel 0: blocking; 1: non-blocking; 2: non-blocking, 4-cycle watchdog; 3: three channels
  rc_issue_ctrl #(.NUM_RC(4), .CH_W(2), .BLOCKING(1), .TIMEOUT_CYC(255), .TO_W(8)) u_blk (
    .clk(clk), .rst_n(rst_n), .dec_rc_req(dec_rc_req), .dec_rc_ch(dec_rc_ch),
    .dec_stall(dec_stall), .dec_kill(dec_kill), .if_kill(if_kill),
    .exe_dmem_val(exe_dmem_val), .dmem_resp_valid(dmem_resp_valid), .rc_done(rc_done),
    .err_clr(err_clr), .rc_cmd(cmd[0]), .rc_active_cnt(cnt[0]), .full_stall(fs[0]),
    .err_timeout(eto[0]), .err_timeout_ch(etc[0]), .err_illegal_ch(eil[0]),
    .err_spurious(esp[0])
  );

  rc_issue_ctrl #(.NUM_RC(4), .CH_W(2), .BLOCKING(0), .TIMEOUT_CYC(255), .TO_W(8)) u_nb (
    .clk(clk), .rst_n(rst_n), .dec_rc_req(dec_rc_req), .dec_rc_ch(dec_rc_ch),
    .dec_stall(dec_stall), .dec_kill(dec_kill), .if_kill(if_kill),
    .exe_dmem_val(exe_dmem_val), .dmem_resp_valid(dmem_resp_valid), .rc_done(rc_done),
    .err_clr(err_clr), .rc_cmd(cmd[1]), .rc_active_cnt(cnt[1]), .full_stall(fs[1]),
    .err_timeout(eto[1]), .err_timeout_ch(etc[1]), .err_illegal_ch(eil[1]),
    .err_spurious(esp[1])
  );

  rc_issue_ctrl #(.NUM_RC(4), .CH_W(2), .BLOCKING(0), .TIMEOUT_CYC(4), .TO_W(8)) u_to (
    .clk(clk), .rst_n(rst_n), .dec_rc_req(dec_rc_req), .dec_rc_ch(dec_rc_ch),
    .dec_stall(dec_stall), .dec_kill(dec_kill), .if_kill(if_kill),
    .exe_dmem_val(exe_dmem_val), .dmem_resp_valid(dmem_resp_valid), .rc_done(rc_done),
    .err_clr(err_clr), .rc_cmd(cmd[2]), .rc_active_cnt(cnt[2]), .full_stall(fs[2]),
    .err_timeout(eto[2]), .err_timeout_ch(etc[2]), .err_illegal_ch(eil[2]),
    .err_spurious(esp[2])
  );

  rc_issue_ctrl #(.NUM_RC(3), .CH_W(2), .BLOCKING(0), .TIMEOUT_CYC(255), .TO_W(8)) u_n3 (
    .clk(clk), .rst_n(rst_n), .dec_rc_req(dec_rc_req), .dec_rc_ch(dec_rc_ch),
    .dec_stall(dec_stall), .dec_kill(dec_kill), .if_kill(if_kill),
    .exe_dmem_val(exe_dmem_val), .dmem_resp_valid(dmem_resp_valid), .rc_done(rc_done[2:0]),
    .err_clr(err_clr), .rc_cmd(cmd3), .rc_active_cnt(cnt3), .full_stall(fs[3]),
    .err_timeout(eto[3]), .err_timeout_ch(etc[3]), .err_illegal_ch(eil[3]),
    .err_spurious(esp[3])
  );

  function automatic logic [31:0] get(input int sel, input int sig);
    logic [31:0] v;
    v = '0;
    case (sig)
      SC:  v = (sel == 3) ? 32'(cmd3) : 32'(cmd[sel]);
      SN:  v = (sel == 3) ? 32'(cnt3) : 32'(cnt[sel]);
      SFS: v = 32'(fs[sel]);
      STO: v = 32'(eto[sel]);
      STC: v = 32'(etc[sel]);
      SIL: v = 32'(eil[sel]);
      default: v = 32'(esp[sel]);
    endcase
    return v;
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      SC:  return "rc_cmd";
      SN:  return "rc_active_cnt";
      SFS: return "full_stall";
      STO: return "err_timeout";
      STC: return "err_timeout_ch";
      SIL: return "err_illegal_ch";
      default: return "err_spurious";
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = get(e.sel, e.sig);
      n_tests++;
      if (act !== 32'(e.val)) begin
        n_fail++;
        $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h",
                 sig_name(e.sig), e.sel, cyc, act, e.val);
      end
    end
  end

  task automatic ex(input int c, input int sel, input int sig, input int val);
    sb.push_back('{cyc: c, sel: sel, sig: sig, val: val});
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    dec_rc_req = 0; dec_rc_ch = 0; dec_stall = 0; dec_kill = 0; if_kill = 0;
    exe_dmem_val = 0; dmem_resp_valid = 0; rc_done = 0; err_clr = 0;
  endtask

  task automatic rst_all();
    idle_inputs();
    rst_n = 0;
    goto(cyc + 2);
    rst_n = 1;
  endtask

  task automatic req(input int ch);
    dec_rc_req = 1;
    dec_rc_ch  = 2'(ch);
  endtask

  int t;

  initial begin
    rst_n = 0;
    idle_inputs();
    @(posedge clk);
    #1;

    // Blocking: one command on ch 2 holds the pipeline until done.
    rst_all(); t = cyc;
    ex(t, 0, SC, 0); ex(t, 0, SFS, 0); ex(t, 0, SN, 0); ex(t, 0, STO, 0);
    for (int k = 1; k <= 5; k++) begin
      ex(t + k, 0, SC, 4); ex(t + k, 0, SFS, 1); ex(t + k, 0, SN, 1);
    end
    ex(t + 6, 0, SC, 0); ex(t + 6, 0, SFS, 0); ex(t + 6, 0, SN, 0);
    req(2);
    goto(t + 1); dec_rc_req = 0;
    goto(t + 5); rc_done = 4'b0100;
    goto(t + 6); rc_done = 0;
    goto(t + 7);

    // Non-blocking: two channels in flight, re-request waits for done.
    rst_all(); t = cyc;
    ex(t + 1, 1, SC, 1); ex(t + 1, 1, SFS, 0);
    ex(t + 2, 1, SC, 3); ex(t + 2, 1, SN, 2); ex(t + 2, 1, SFS, 0);
    ex(t + 3, 1, SC, 3); ex(t + 3, 1, SFS, 1);
    ex(t + 4, 1, SC, 3); ex(t + 4, 1, SFS, 1);
    ex(t + 5, 1, SC, 2); ex(t + 5, 1, SN, 1); ex(t + 5, 1, SFS, 0);
    ex(t + 6, 1, SC, 3); ex(t + 6, 1, SN, 2); ex(t + 6, 1, SFS, 0);
    req(0);
    goto(t + 1); req(1);
    goto(t + 2); dec_rc_req = 0;
    goto(t + 3); req(0);
    goto(t + 4); rc_done = 4'b0001;
    goto(t + 5); rc_done = 0;
    goto(t + 6); dec_rc_req = 0;
    goto(t + 7);

    // Watchdog: 4-cycle limit on ch 3, clear, then done on the expiry cycle.
    rst_all(); t = cyc;
    ex(t + 1, 2, SC, 8); ex(t + 4, 2, SC, 8); ex(t + 4, 2, STO, 0);
    ex(t + 5, 2, SC, 0); ex(t + 5, 2, STO, 1); ex(t + 5, 2, STC, 3);
    ex(t + 6, 2, STO, 1);
    ex(t + 7, 2, STO, 0); ex(t + 7, 2, STC, 0);
    ex(t + 12, 2, SC, 8);
    ex(t + 13, 2, SC, 0); ex(t + 13, 2, STO, 0); ex(t + 13, 2, SSP, 0);
    ex(t + 14, 2, STO, 0);
    req(3);
    goto(t + 1); dec_rc_req = 0;
    goto(t + 6); err_clr = 1;
    goto(t + 7); err_clr = 0;
    goto(t + 8); req(3);
    goto(t + 9); dec_rc_req = 0;
    goto(t + 12); rc_done = 4'b1000;
    goto(t + 13); rc_done = 0;
    goto(t + 15);

    // dmem stall holds the request for three cycles, then it is accepted.
    rst_all(); t = cyc;
    for (int k = 0; k < 3; k++) ex(t + k, 1, SFS, 1);
    ex(t + 1, 1, SC, 0); ex(t + 2, 1, SC, 0);
    ex(t + 3, 1, SC, 0); ex(t + 3, 1, SFS, 0);
    ex(t + 4, 1, SC, 4); ex(t + 4, 1, SFS, 0);
    exe_dmem_val = 1; req(2);
    goto(t + 3); dmem_resp_valid = 1;
    goto(t + 4); idle_inputs();
    goto(t + 5);

    // Kill drops the request; illegal channel on the 3-channel instance.
    rst_all(); t = cyc;
    ex(t, 1, SFS, 0); ex(t, 3, SFS, 0);
    ex(t + 1, 1, SC, 0);
    ex(t + 2, 3, SIL, 0); ex(t + 2, 3, SFS, 0);
    ex(t + 3, 3, SIL, 1); ex(t + 3, 3, SC, 0);
    req(1); dec_kill = 1;
    goto(t + 1); req(3);
    goto(t + 2); dec_kill = 0;
    goto(t + 3); dec_rc_req = 0;
    goto(t + 4);

    // Spurious done with a same-cycle clear, then reset mid-command.
    rst_all(); t = cyc;
    ex(t, 1, SSP, 0); ex(t + 1, 1, SSP, 1);
    ex(t + 3, 1, SC, 1); ex(t + 3, 1, SN, 1); ex(t + 3, 2, SC, 1);
    ex(t + 4, 1, SC, 0); ex(t + 4, 1, SN, 0); ex(t + 4, 1, SFS, 0);
    ex(t + 4, 1, SSP, 0); ex(t + 4, 1, STO, 0); ex(t + 4, 2, SC, 0);
    ex(t + 8, 2, STO, 0); ex(t + 8, 2, SC, 0);
    rc_done = 4'b0010; err_clr = 1;
    goto(t + 1); rc_done = 0; err_clr = 0; req(0);
    goto(t + 2); dec_rc_req = 0;
    goto(t + 3); rst_n = 0;
    goto(t + 7); rst_n = 1;
    goto(t + 9);

    for (int k = 0; k < 50 && sb.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
